// File: rtl/ct_rd_arbiter.sv
// ct_rd_arbiter
//   Shares the single read port of the ciphertext memory between NREQ crack
//   cores. Grants one requester per cycle in round-robin order; a core that
//   raises lock when it wins keeps the port (burst ownership) so it can read
//   its length and message bytes back-to-back. Read data is returned one cycle
//   after the grant, tagged by a one-hot rvalid.
//
// Ports
//   clk           clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   req_i         per-core read request, held with its address until granted
//   lock_i        per-core burst-ownership request, honoured when that core wins
//   addr_i        packed addresses, core i at [i*AW +: AW]
//   gnt_o         combinational one-hot (or zero) grant; read issued this cycle
//   rvalid_o      registered one-hot tag: rdata_o belongs to core i this cycle
//   rdata_o       memory read data passthrough
//   busy_o        high while a core owns the port
//   mem_addr_o    memory address, zero when nothing is granted
//   mem_rddata_i  memory read data, valid one cycle after mem_addr_o

module ct_rd_arbiter #(
    parameter int NREQ     = 4,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAXBURST = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      lock_i,
    input  logic [NREQ*AW-1:0]   addr_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      rvalid_o,
    output logic [DW-1:0]        rdata_o,
    output logic                 busy_o,
    output logic [AW-1:0]        mem_addr_o,
    input  logic [DW-1:0]        mem_rddata_i
);

    localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [8:0] BCNT_MAX = 9'd511;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [8:0]      bcnt_q, bcnt_d;
    logic [8:0]      bcnt_inc;
    logic [NREQ-1:0] rvalid_q;

    logic            hit;
    logic [PW-1:0]   win;
    logic [PW-1:0]   scan_idx;
    logic [NREQ-1:0] gnt_c;

    // Modulo-NREQ increment; NREQ need not be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        if (int'(i) == NREQ - 1) begin
            return '0;
        end
        return i + PW'(1);
    endfunction

    // Winner selection. In ARB the scan runs from the highest offset down so
    // the last hit written is the first requester at or after ptr.
    always_comb begin
        hit      = 1'b0;
        win      = '0;
        scan_idx = '0;
        if (state_q == OWN) begin
            hit = req_i[owner_q];
            win = owner_q;
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                scan_idx = PW'((int'(ptr_q) + k) % NREQ);
                if (req_i[scan_idx]) begin
                    hit = 1'b1;
                    win = scan_idx;
                end
            end
        end
    end

    always_comb begin
        gnt_c      = '0;
        mem_addr_o = '0;
        if (hit) begin
            gnt_c[win] = 1'b1;
            mem_addr_o = addr_i[int'(win)*AW +: AW];
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        bcnt_d   = bcnt_q;
        // Saturates so an unlimited burst never wraps back to a small count.
        bcnt_inc = (bcnt_q == BCNT_MAX) ? bcnt_q : bcnt_q + 9'd1;
        case (state_q)
            ARB: begin
                if (hit) begin
                    ptr_d = wrap_inc(win);
                    if (lock_i[win] && (MAXBURST != 1)) begin
                        state_d = OWN;
                        owner_d = win;
                        bcnt_d  = 9'd1;
                    end
                end
            end
            OWN: begin
                if (hit) begin
                    bcnt_d = bcnt_inc;
                end
                // A grant issued in the exit cycle still completes; the
                // pointer skips past the owner so it waits its turn.
                if (!lock_i[owner_q] ||
                    (hit && (MAXBURST != 0) && (bcnt_inc == 9'(MAXBURST)))) begin
                    state_d = ARB;
                    ptr_d   = wrap_inc(owner_q);
                    bcnt_d  = '0;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB;
            ptr_q    <= '0;
            owner_q  <= '0;
            bcnt_q   <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            bcnt_q   <= bcnt_d;
            rvalid_q <= gnt_c;
        end
    end

    assign gnt_o    = gnt_c;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = mem_rddata_i;
    assign busy_o   = (state_q == OWN);

endmodule
